manual_badpixel_tracker: RTL
============================

# manual_badpixel_tracker

Next-generation manual defect-table lookup for the DPC pipeline: takes a host-written list of known bad-pixel coordinates and flags matching pixels in the raster stream so the correction stage can replace them. Compared with the previous checker it is fully parametrised in coordinate width and table depth and double-buffers the table, so a new list can be loaded without a frame tear. A two-entry prefetch sustains matches on back-to-back pixels, and table entries the raster has already passed are skipped, so the walk cannot stall. It sits beside the dynamic detector, single clock domain.

## Interface
- WIDTH_BITS, 10, column coordinate width (1..16)
- HEIGHT_BITS, 10, row coordinate width (1..16)
- DEPTH, 128, entries per bank
- ADDR_BITS, 7, table address width; DEPTH <= 2^ADDR_BITS
- clk  in  1  pixel clock, all logic rising-edge
- rst_n  in  1  asynchronous active-low reset
- frame_start  in  1  level, high during vertical blank; rising edge = new frame
- in_valid  in  1  pixel beat valid
- in_x  in  WIDTH_BITS  column of beat
- in_y  in  HEIGHT_BITS  row of beat
- wen_lut  in  1  write strobe into shadow bank
- waddr_lut  in  ADDR_BITS  shadow write address
- wdata_lut  in  32  entry: x = [16 +: WIDTH_BITS], y = [0 +: HEIGHT_BITS], other bits ignored
- cfg_num  in  ADDR_BITS+1  shadow entry count, sampled at commit
- cfg_commit  in  1  pulse: shadow bank ready, swap at next frame edge
- out_valid  out  1  registered in_valid
- out_match  out  1  beat is a listed bad pixel
- out_x  out  WIDTH_BITS  registered in_x
- out_y  out  HEIGHT_BITS  registered in_y
- active_bank  out  1  bank used for lookup
- commit_pending  out  1  commit latched, swap not yet done
- frame_hits  out  ADDR_BITS+1  matches in previous frame
- frame_skips  out  ADDR_BITS+1  entries skipped in previous frame

## Operation
- Two banks of DEPTH x (WIDTH_BITS+HEIGHT_BITS) inferred RAM, 1-cycle read. Writes always go to bank ~active_bank; the active bank is never written.
- cfg_commit: latch min(cfg_num, DEPTH) as pending count, set commit_pending. Second commit before swap overwrites pending count.
- Frame edge (frame_start high, registered copy low; registered copy resets to 1 so reset never fakes an edge): if commit_pending, toggle active_bank, load active count from pending, clear commit_pending; always rptr<=0, head_valid/pref_valid<=0, copy hit/skip counters to frame_hits/frame_skips and clear them.
- Load: FSM IDLE -> FETCH0 -> FETCH1 -> RUN. Head H = entry[rptr], prefetch P = entry[rptr+1]; valid only if index < active count.
- Entries must be raster-sorted ascending by key {y,x}. Per valid beat in RUN, key C={in_y,in_x}:
  - C == H: match, advance 1.
  - C > H and C == P (P valid): match, advance 2, skips+1.
  - C > H, C != P: no match, advance 1, skips+1 (P consumed next beat).
  - C < H or head invalid: no match, no advance.
- Advancing keeps H/P refilled so consecutive beats matching consecutive entries all match.
- Counters saturate at all-ones. Count 0 gives no matches.
- Reset mid-frame: all state cleared, active_bank=0, counts 0; RAM contents undefined and not relied on. No matches until commit plus frame edge.

## Timing
- Reset values: out_valid 0, out_match 0, out_x/out_y 0, active_bank 0, commit_pending 0, frame_hits 0, frame_skips 0.
- Pixel path latency 1: beat at cycle N appears on out_* at N+1; out_match valid only with out_valid.
- Frame edge seen at cycle T: swap visible on active_bank at T+1; RUN reached at T+3. Beats before T+3 never match. Blanking guarantees no beats there.
- frame_hits/frame_skips update at T+1.
- cfg_commit and frame edge in same cycle: swap occurs at that edge.
- wen_lut in the same cycle as the swap writes the old shadow bank, i.e. the new active bank. Writes must not coincide with the edge.

## Test plan
- Table {(5,2),(6,2),(7,2)}, commit, frame over 16x4: out_match at exactly those three beats, consecutive, one cycle after input; frame_hits=3 next frame.
- Table {(3,0),(1,1)} with beat (3,0) dropped: (1,1) still matches, frame_skips=1, frame_hits=1.
- Stream stalls (in_valid low) between matching beats: no advance while idle, both entries match.
- Load bank B mid-frame while bank A is active: frame unaffected; after edge active_bank=1 and only B's entries match; commit_pending 1 -> 0.
- cfg_num=200 with DEPTH=128: count clamps to 128; cfg_num=0: no matches.
- Assert rst_n low mid-frame: all outputs 0 asynchronously; no matches until commit plus a frame edge.

Source files
------------

// File: rtl/manual_badpixel_tracker.sv
`timescale 1ns/1ps
// Purpose : flags raster beats whose {y,x} appears in a host-loaded, raster-sorted
//           bad-pixel table. The table is double-buffered and swaps only at a frame edge.
// Latency : 1 cycle from in_* to out_*. The table walk needs 3 cycles after a frame edge.
// Backpr. : none. A beat is accepted on every cycle that in_valid is high, and the
//           walk never stalls the stream.
// Ports   : clk/rst_n        clock and async active-low reset
//           frame_start      vblank level; its rising edge starts a frame
//           in_valid/x/y     raster beat in
//           wen/waddr/wdata  shadow-bank table write
//           cfg_num/commit   shadow entry count and swap request
//           out_valid/match/x/y  registered beat plus the match flag
//           active_bank, commit_pending, frame_hits, frame_skips  status
module manual_badpixel_tracker #(
  parameter int WIDTH_BITS  = 10,
  parameter int HEIGHT_BITS = 10,
  parameter int DEPTH       = 128,
  parameter int ADDR_BITS   = 7
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   frame_start,
  input  logic                   in_valid,
  input  logic [WIDTH_BITS-1:0]  in_x,
  input  logic [HEIGHT_BITS-1:0] in_y,
  input  logic                   wen_lut,
  input  logic [ADDR_BITS-1:0]   waddr_lut,
  input  logic [31:0]            wdata_lut,
  input  logic [ADDR_BITS:0]     cfg_num,
  input  logic                   cfg_commit,
  output logic                   out_valid,
  output logic                   out_match,
  output logic [WIDTH_BITS-1:0]  out_x,
  output logic [HEIGHT_BITS-1:0] out_y,
  output logic                   active_bank,
  output logic                   commit_pending,
  output logic [ADDR_BITS:0]     frame_hits,
  output logic [ADDR_BITS:0]     frame_skips
);

  localparam int KW = HEIGHT_BITS + WIDTH_BITS;
  localparam int CW = ADDR_BITS + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);
  localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};
  localparam logic [CW-1:0] ONE       = CW'(1);
  localparam logic [CW-1:0] TWO       = CW'(2);

  typedef enum logic [1:0] {ST_IDLE, ST_FETCH0, ST_FETCH1, ST_RUN} state_t;

  state_t state_q, state_d;

  logic          fs_q;
  logic          frame_edge;
  logic          run_en;
  logic          walk_en;

  logic          active_bank_q, active_bank_d;
  logic          commit_pending_q, commit_pending_d;
  logic [CW-1:0] pend_cnt_q, pend_cnt_d;
  logic [CW-1:0] active_cnt_q, active_cnt_d;
  logic [CW-1:0] rptr_q, rptr_d;
  logic          head_vld_q, head_vld_d;
  logic          pref_vld_q, pref_vld_d;
  logic [CW-1:0] hits_q, hits_d;
  logic [CW-1:0] skips_q, skips_d;
  logic [CW-1:0] frame_hits_q, frame_hits_d;
  logic [CW-1:0] frame_skips_q, frame_skips_d;

  logic                   out_valid_q;
  logic                   out_match_q;
  logic [WIDTH_BITS-1:0]  out_x_q;
  logic [HEIGHT_BITS-1:0] out_y_q;

  logic          match;
  logic          skip;
  logic [CW-1:0] cfg_clamped;
  logic          commit_eff;
  logic [CW-1:0] commit_cnt_eff;

  // Table storage: one write port into the shadow bank and two read ports
  // (head and prefetch) per bank.
  logic [KW-1:0] bank0_mem [DEPTH];
  logic [KW-1:0] bank1_mem [DEPTH];
  logic [KW-1:0] b0_h_q, b0_p_q, b1_h_q, b1_p_q;
  logic [KW-1:0] head_key, pref_key, cur_key, wkey;
  logic [CW-1:0] pidx;
  logic [ADDR_BITS-1:0] ra_h, ra_p;
  logic          unused_wdata;

  // A frame starts on the rising edge of the vblank level. fs_q resets high,
  // so a frame_start that is already high when reset is released is not an edge.
  assign frame_edge = frame_start & ~fs_q;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    if (frame_edge) begin
      state_d = ST_FETCH0;
    end else begin
      case (state_q)
        ST_FETCH0: state_d = ST_FETCH1;
        ST_FETCH1: state_d = ST_RUN;
        default:   state_d = state_q;
      endcase
    end
  end

  // ---------------- FSM: outputs ----------------
  // FETCH0 reads the new bank at entries 0 and 1. FETCH1 sees that data and
  // raises the head/prefetch valid flags for RUN.
  always_comb begin
    run_en  = 1'b0;
    walk_en = 1'b0;
    case (state_q)
      ST_FETCH1: walk_en = 1'b1;
      ST_RUN: begin
        run_en  = 1'b1;
        walk_en = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------- table RAM ----------------
  assign wkey         = {wdata_lut[0 +: HEIGHT_BITS], wdata_lut[16 +: WIDTH_BITS]};
  assign unused_wdata = ^wdata_lut;

  // Writes go only to the bank that is not active.
  always_ff @(posedge clk) begin
    if (wen_lut && ({1'b0, waddr_lut} < DEPTH_CNT)) begin
      if (active_bank_q) bank0_mem[waddr_lut] <= wkey;
      else               bank1_mem[waddr_lut] <= wkey;
    end
  end

  // The read address follows rptr_d, so the head and prefetch registers always
  // hold entry[rptr_q] and entry[rptr_q+1]. Indices past the table wrap to 0,
  // and the valid flags mask them.
  assign pidx = rptr_d + ONE;
  assign ra_h = (rptr_d < DEPTH_CNT) ? rptr_d[ADDR_BITS-1:0] : '0;
  assign ra_p = (pidx   < DEPTH_CNT) ? pidx[ADDR_BITS-1:0]   : '0;

  always_ff @(posedge clk) begin
    b0_h_q <= bank0_mem[ra_h];
    b0_p_q <= bank0_mem[ra_p];
    b1_h_q <= bank1_mem[ra_h];
    b1_p_q <= bank1_mem[ra_p];
  end

  assign head_key = active_bank_q ? b1_h_q : b0_h_q;
  assign pref_key = active_bank_q ? b1_p_q : b0_p_q;
  assign cur_key  = {in_y, in_x};

  // ---------------- table walk ----------------
  // A beat past the head consumes the head. If the beat also equals the
  // prefetch entry, it matches and consumes the prefetch as well. A beat
  // before the head leaves the pointer alone, so idle cycles never lose entries.
  always_comb begin
    match  = 1'b0;
    skip   = 1'b0;
    rptr_d = rptr_q;
    if (frame_edge) begin
      rptr_d = '0;
    end else if (run_en && in_valid && head_vld_q) begin
      if (cur_key == head_key) begin
        match  = 1'b1;
        rptr_d = rptr_q + ONE;
      end else if (cur_key > head_key) begin
        skip = 1'b1;
        if (pref_vld_q && (cur_key == pref_key)) begin
          match  = 1'b1;
          rptr_d = rptr_q + TWO;
        end else begin
          rptr_d = rptr_q + ONE;
        end
      end
    end
  end

  always_comb begin
    head_vld_d = 1'b0;
    pref_vld_d = 1'b0;
    if (walk_en && !frame_edge) begin
      head_vld_d = (rptr_d < active_cnt_q);
      pref_vld_d = (pidx   < active_cnt_q);
    end
  end

  // ---------------- statistics ----------------
  always_comb begin
    hits_d        = hits_q;
    skips_d       = skips_q;
    frame_hits_d  = frame_hits_q;
    frame_skips_d = frame_skips_q;
    if (frame_edge) begin
      frame_hits_d  = hits_q;
      frame_skips_d = skips_q;
      hits_d        = '0;
      skips_d       = '0;
    end else begin
      if (match && (hits_q  != CNT_MAX)) hits_d  = hits_q  + ONE;
      if (skip  && (skips_q != CNT_MAX)) skips_d = skips_q + ONE;
    end
  end

  // ---------------- commit / bank swap ----------------
  assign cfg_clamped    = (cfg_num > DEPTH_CNT) ? DEPTH_CNT : cfg_num;
  // A commit in the edge cycle takes effect at that same edge.
  assign commit_eff     = commit_pending_q | cfg_commit;
  assign commit_cnt_eff = cfg_commit ? cfg_clamped : pend_cnt_q;

  always_comb begin
    active_bank_d    = active_bank_q;
    active_cnt_d     = active_cnt_q;
    commit_pending_d = commit_pending_q;
    pend_cnt_d       = pend_cnt_q;
    if (frame_edge) begin
      if (commit_eff) begin
        active_bank_d    = ~active_bank_q;
        active_cnt_d     = commit_cnt_eff;
        commit_pending_d = 1'b0;
        pend_cnt_d       = commit_cnt_eff;
      end
    end else if (cfg_commit) begin
      commit_pending_d = 1'b1;
      pend_cnt_d       = cfg_clamped;
    end
  end

  // ---------------- state registers ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fs_q             <= 1'b1;
      active_bank_q    <= 1'b0;
      commit_pending_q <= 1'b0;
      pend_cnt_q       <= '0;
      active_cnt_q     <= '0;
      rptr_q           <= '0;
      head_vld_q       <= 1'b0;
      pref_vld_q       <= 1'b0;
      hits_q           <= '0;
      skips_q          <= '0;
      frame_hits_q     <= '0;
      frame_skips_q    <= '0;
      out_valid_q      <= 1'b0;
      out_match_q      <= 1'b0;
      out_x_q          <= '0;
      out_y_q          <= '0;
    end else begin
      fs_q             <= frame_start;
      active_bank_q    <= active_bank_d;
      commit_pending_q <= commit_pending_d;
      pend_cnt_q       <= pend_cnt_d;
      active_cnt_q     <= active_cnt_d;
      rptr_q           <= rptr_d;
      head_vld_q       <= head_vld_d;
      pref_vld_q       <= pref_vld_d;
      hits_q           <= hits_d;
      skips_q          <= skips_d;
      frame_hits_q     <= frame_hits_d;
      frame_skips_q    <= frame_skips_d;
      out_valid_q      <= in_valid;
      out_match_q      <= match;
      out_x_q          <= in_x;
      out_y_q          <= in_y;
    end
  end

  assign out_valid      = out_valid_q;
  assign out_match      = out_match_q;
  assign out_x          = out_x_q;
  assign out_y          = out_y_q;
  assign active_bank    = active_bank_q;
  assign commit_pending = commit_pending_q;
  assign frame_hits     = frame_hits_q;
  assign frame_skips    = frame_skips_q;

endmodule
